// File: rtl/weight_pair_stager_if.sv
// weight_pair_stager_if: staged weight-pair stream toward the consumer.
// master drives the pair and valid/last; slave returns ready.
interface weight_pair_stager_if #(
    parameter int DATA_WIDTH = 16
);

    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic                  w_valid;
    logic                  w_ready;
    logic                  w_last;

    modport master (
        output w_a,
        output w_b,
        output w_valid,
        output w_last,
        input  w_ready
    );

    modport slave (
        input  w_a,
        input  w_b,
        input  w_valid,
        input  w_last,
        output w_ready
    );

endinterface

// File: rtl/weight_pair_stager.sv
// weight_pair_stager: paces a weight ROM address generator and stages pairs.
// Define WEIGHT_STAGER_BYPASS_EN to let a pair skip an empty FIFO.
module weight_pair_stager #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int ROM_LATENCY = 2,
    parameter int PIXEL_PAIRS = 13,
    parameter int TOTAL_PAIRS = 13 * 64 * 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  gen_enable,
    input  logic [DATA_WIDTH-1:0] rom_qa,
    input  logic [DATA_WIDTH-1:0] rom_qb,
    weight_pair_stager_if.master  wp,
    output logic                  done
);

    localparam int CNT_W  = $clog2(TOTAL_PAIRS + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int PIX_W  = $clog2(PIXEL_PAIRS + 1);
    localparam int IFL_W  = $clog2(ROM_LATENCY + 1);
    localparam int OCC_W  = $clog2(FIFO_DEPTH + ROM_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   done_next;

    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] accepted;

    logic [ROM_LATENCY-1:0] tags;
    logic [IFL_W-1:0]       inflight;
    logic [OCC_W-1:0]       occupancy;

    logic [PIX_W-1:0] pix;
    logic             push;
    logic             push_last;

    logic [DATA_WIDTH-1:0] mem_a [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_b [FIFO_DEPTH];
    logic                  mem_last [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_count;

    logic fifo_empty;
    logic bypass;
    logic store;
    logic pop_fifo;
    logic pop;
    logic last_pop;
    logic start_pass;

    // Pairs issued to the ROM but not yet landed in the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + IFL_W'(tags[i]);
        end
    end

    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight);

    assign gen_enable = (state == RUN)
                     && (issued < CNT_W'(TOTAL_PAIRS))
                     && (occupancy < OCC_W'(FIFO_DEPTH));

    assign push      = tags[ROM_LATENCY-1];
    assign push_last = (pix == PIX_W'(PIXEL_PAIRS - 1));

    assign fifo_empty = (fifo_count == '0);

`ifdef WEIGHT_STAGER_BYPASS_EN
    assign bypass = push && fifo_empty && wp.w_ready;
`else
    assign bypass = 1'b0;
`endif

    assign store    = push && !bypass;
    assign pop_fifo = !fifo_empty && wp.w_ready;
    assign pop      = pop_fifo || bypass;
    assign last_pop = pop && (accepted == CNT_W'(TOTAL_PAIRS - 1));

    assign start_pass = (state == IDLE) && start;

    assign wp.w_valid = !fifo_empty || bypass;
    assign wp.w_a     = bypass ? rom_qa    : mem_a[rd_ptr];
    assign wp.w_b     = bypass ? rom_qb    : mem_b[rd_ptr];
    assign wp.w_last  = bypass ? push_last : mem_last[rd_ptr];

    // Pass sequencing: issue in RUN, wait for the tail in DRAIN.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (gen_enable &&
                    issued == CNT_W'(TOTAL_PAIRS - 1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and the registered end-of-pass pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    // Issued and accepted counts restart on each accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued   <= '0;
            accepted <= '0;
        end else if (start_pass) begin
            issued   <= '0;
            accepted <= '0;
        end else begin
            if (gen_enable) begin
                issued <= issued + 1'b1;
            end
            if (pop) begin
                accepted <= accepted + 1'b1;
            end
        end
    end

    // Tag pipeline mirrors the ROM read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tags <= '0;
        end else begin
            tags[0] <= gen_enable;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    // Pixel position of each landed pair, wrapping per pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix <= '0;
        end else if (push) begin
            if (push_last) begin
                pix <= '0;
            end else begin
                pix <= pix + 1'b1;
            end
        end
    end

    // FIFO storage; cleared so the head reads zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_a[i]    <= '0;
                mem_b[i]    <= '0;
                mem_last[i] <= 1'b0;
            end
        end else if (store) begin
            mem_a[wr_ptr]    <= rom_qa;
            mem_b[wr_ptr]    <= rom_qb;
            mem_last[wr_ptr] <= push_last;
        end
    end

    // FIFO pointers and fill level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fifo) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({store, pop_fifo})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A landing pair must always find room in the FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(store && !pop_fifo &&
                      fifo_count == FCNT_W'(FIFO_DEPTH)))
            else $error("weight_pair_stager: fifo overflow");
        end
    end

endmodule

// File: doc/weight_pair_stager.md
WEIGHT_PAIR_STAGER -- requirements
Module: weight_pair_stager

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of one weight word.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the staging FIFO entry count; it is a power of two and at least 2.
REQ-003 Parameter ROM_LATENCY, default 2, SHALL set the cycles from a gen_enable-high cycle to its pair arriving on rom_qa/rom_qb; the range is 1 to 4.
REQ-004 Parameter PIXEL_PAIRS, default 13, SHALL set the number of pairs per output pixel.
REQ-005 Parameter TOTAL_PAIRS, default 13*64*6, SHALL set the number of pairs in one layer pass.
REQ-006 Port clk, input, 1 bit, SHALL be the clock.
REQ-007 Port reset, input, 1 bit, SHALL be the asynchronous active-high reset.
REQ-008 Port start, input, 1 bit, SHALL begin a pass when pulsed while idle.
REQ-009 Port gen_enable, output, 1 bit, SHALL be the advance strobe to the weight address generator.
REQ-010 Ports rom_qa and rom_qb, inputs, DATA_WIDTH each, SHALL carry the weight ROM port A and port B read data.
REQ-011 Ports w_a and w_b, outputs, DATA_WIDTH each, SHALL carry the staged weight pair.
REQ-012 Port w_valid, output, 1 bit, SHALL indicate that the staged pair is present.
REQ-013 Port w_ready, input, 1 bit, SHALL indicate that the consumer accepts the staged pair.
REQ-014 Port w_last, output, 1 bit, SHALL mark the final pair of an output pixel.
REQ-015 Port done, output, 1 bit, SHALL be a one-cycle pulse after the final pair of the pass is accepted.

Function
REQ-016 The block SHALL have three states: IDLE, RUN and DRAIN. start in IDLE SHALL move to RUN. RUN SHALL move to DRAIN in the cycle the issued count reaches TOTAL_PAIRS. DRAIN SHALL move to IDLE when the accepted count reaches TOTAL_PAIRS.
REQ-017 gen_enable SHALL be combinational and SHALL be high only when all hold: state is RUN, issued < TOTAL_PAIRS, and fifo_count + inflight < FIFO_DEPTH.
REQ-018 Each gen_enable-high cycle SHALL increment issued and SHALL shift a 1 into a ROM_LATENCY-deep inflight tag pipeline; each other cycle SHALL shift in a 0.
REQ-019 When a 1 exits the tag pipeline, {rom_qa, rom_qb} SHALL be written to the FIFO in that same cycle. Overflow is impossible by REQ-017 and SHALL be flagged by an assertion.
REQ-020 FIFO writes SHALL carry a last bit. The bit SHALL be set when a PIXEL_PAIRS-modulo write counter equals PIXEL_PAIRS-1. That counter SHALL wrap to 0 after the set.
REQ-021 The FIFO head SHALL drive w_a, w_b and w_last. w_valid SHALL equal (fifo_count != 0), and these outputs SHALL be registered with zero bubble.
REQ-022 A pop SHALL occur when w_valid and w_ready are both high. w_a, w_b and w_last SHALL hold stable while w_valid=1 and w_ready=0.
REQ-023 A simultaneous push and pop SHALL leave fifo_count unchanged, including when the FIFO is full or empty.
REQ-024 done SHALL pulse for exactly one cycle, in the cycle after the pop of pair TOTAL_PAIRS; the state SHALL be IDLE in that same cycle.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 All counters SHALL be sized with $clog2 of their maximum value plus 1, and SHALL have no wrap other than the one specified in REQ-020.

Reset
REQ-027 Reset SHALL clear state to IDLE; issued, accepted, fifo_count, FIFO pointers, the pixel counter and the tag pipeline to 0; and w_valid, w_last, done and gen_enable to 0. w_a and w_b SHALL reset to 0.
REQ-028 Reset asserted mid-pass SHALL discard in-flight and stored pairs; the generator shares the same reset.

Configuration
REQ-029 Macro WEIGHT_STAGER_BYPASS_EN SHALL control a bypass path.
REQ-030 With WEIGHT_STAGER_BYPASS_EN defined, a write into an empty FIFO with w_ready=1 SHALL present the pair combinationally on w_a/w_b/w_valid in that cycle, pop it, and not store it. Pass latency SHALL then be ROM_LATENCY cycles.
REQ-031 Without WEIGHT_STAGER_BYPASS_EN defined, all outputs SHALL come from the FIFO registers, and latency SHALL be ROM_LATENCY+1 cycles.

Verification
REQ-032 Test: TOTAL_PAIRS=26, PIXEL_PAIRS=13, w_ready held 1, rom data = issue index. Required: 26 pairs in order; w_last only on pairs 13 and 26; done pulses one cycle after pair 26; gen_enable high for 26 consecutive cycles.
REQ-033 Test: w_ready=0 from the cycle after start. Required: gen_enable high for exactly FIFO_DEPTH=4 cycles, then low; after w_ready rises, the outputs hold pairs 0..3 in order, and no pair is lost.
REQ-034 Test: w_ready toggled at 50% at random for 1000 cycles. Required: the output sequence equals the issue sequence; fifo_count never exceeds 4; no overflow assertion fires.
REQ-035 Test: reset asserted at pair 7 of a pass. Required: next cycle w_valid=0, gen_enable=0, state=IDLE; a new start yields pair 0 first with correct w_last placement.
REQ-036 Test: start pulsed during RUN and during DRAIN. Required: no effect on the counts; exactly one done per pass.
REQ-037 Test: build with WEIGHT_STAGER_BYPASS_EN defined and w_ready=1. Required: the first pair appears ROM_LATENCY=2 cycles after the first gen_enable; without the macro it appears after 3 cycles.
